fft_bfly_pe: RTL and testbench



---
 rtl/fft_bfly_pe.sv | 188 ++++++++++++++++++
 tb/tb_fft_bfly_pe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_pe.sv
`default_nettype none
// ============================================================================
// fft_bfly_pe : radix-2 DIT butterfly PE, 3-stage pipeline, credit-based FIFO
// Revision    : 1.0
// ============================================================================
module fft_bfly_pe #(
  parameter int DATA_W       = 16,
  parameter int TW_W         = 16,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [2*DATA_W-1:0]             a,
  input  logic [2*DATA_W-1:0]             b,
  input  logic [TW_W-1:0]                 tw_re,
  input  logic [TW_W-1:0]                 tw_im,
  input  logic                            inverse,
  input  logic                            scale,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*DATA_W-1:0]             fft_a,
  output logic [2*DATA_W-1:0]             fft_b,
  output logic                            sat_flag,
  input  logic                            sat_clr,
  output logic [$clog2(BUFFER_DEPTH):0]   level
);

  localparam int CW  = 2 * DATA_W;
  localparam int WW  = TW_W + 1;        // holds the negation of the most negative twiddle
  localparam int PW  = DATA_W + WW;
  localparam int SW  = DATA_W + 4;
  localparam int AW  = $clog2(BUFFER_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CRW = LW + 1;

  localparam logic signed [PW-1:0] C_RND = PW'(2 ** (TW_W - 3));
  localparam logic signed [SW-1:0] C_ONE = SW'(1);
  localparam logic signed [SW-1:0] C_MAX = SW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [SW-1:0] C_MIN = SW'(-(2 ** (DATA_W - 1)));

  function automatic logic signed [SW-1:0] f_half(input logic signed [SW-1:0] x,
                                                  input logic en);
    logic signed [SW-1:0] t;
    t = x + C_ONE;
    return en ? (t >>> 1) : x;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [DATA_W:0] f_clip(input logic signed [SW-1:0] x);
    logic [DATA_W:0] r;
    if (x > C_MAX)      r = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    else if (x < C_MIN) r = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else                r = {1'b0, x[DATA_W-1:0]};
    return r;
  endfunction

  logic                 accept;
  logic signed [WW-1:0] wr_in, wi_in, wi_ext;

  assign accept = in_valid && in_ready;
  assign wr_in  = {tw_re[TW_W-1], tw_re};
  assign wi_ext = {tw_im[TW_W-1], tw_im};
  assign wi_in  = inverse ? -wi_ext : wi_ext;

  logic                 s1_v_q, s2_v_q, s3_v_q;
  logic [CW-1:0]        s1_a_q, s1_b_q;
  logic signed [WW-1:0] s1_wr_q, s1_wi_q;
  logic                 s1_sc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
    end else begin
      s1_v_q <= accept;
      s2_v_q <= s1_v_q;
      s3_v_q <= s2_v_q;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_q  <= a;
      s1_b_q  <= b;
      s1_wr_q <= wr_in;
      s1_wi_q <= wi_in;
      s1_sc_q <= scale;
    end
  end

  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
  logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;

  assign br_x = {{(PW-DATA_W){s1_b_q[CW-1]}},     s1_b_q[CW-1:DATA_W]};
  assign bi_x = {{(PW-DATA_W){s1_b_q[DATA_W-1]}}, s1_b_q[DATA_W-1:0]};
  assign wr_x = {{(PW-WW){s1_wr_q[WW-1]}}, s1_wr_q};
  assign wi_x = {{(PW-WW){s1_wi_q[WW-1]}}, s1_wi_q};
  assign rr_d = br_x * wr_x;
  assign ii_d = bi_x * wi_x;
  assign ri_d = br_x * wi_x;
  assign ir_d = bi_x * wr_x;

  logic [CW-1:0]        s2_a_q;
  logic                 s2_sc_q;
  logic signed [PW-1:0] s2_rr_q, s2_ii_q, s2_ri_q, s2_ir_q;

  always_ff @(posedge clk) begin
    s2_a_q  <= s1_a_q;
    s2_sc_q <= s1_sc_q;
    s2_rr_q <= rr_d;
    s2_ii_q <= ii_d;
    s2_ri_q <= ri_d;
    s2_ir_q <= ir_d;
  end

  logic signed [PW-1:0] sum_re, sum_im;
  logic signed [SW-1:0] bw_re, bw_im, ar_x, ai_x;
  logic [DATA_W:0]      res_ar, res_ai, res_br, res_bi;

  assign sum_re = s2_rr_q - s2_ii_q + C_RND;
  assign sum_im = s2_ri_q + s2_ir_q + C_RND;
  // Post-shift magnitude fits comfortably in SW bits for any twiddle code.
  assign bw_re  = SW'(sum_re >>> (TW_W - 2));
  assign bw_im  = SW'(sum_im >>> (TW_W - 2));
  assign ar_x   = {{(SW-DATA_W){s2_a_q[CW-1]}},     s2_a_q[CW-1:DATA_W]};
  assign ai_x   = {{(SW-DATA_W){s2_a_q[DATA_W-1]}}, s2_a_q[DATA_W-1:0]};
  assign res_ar = f_clip(f_half(ar_x + bw_re, s2_sc_q));
  assign res_ai = f_clip(f_half(ai_x + bw_im, s2_sc_q));
  assign res_br = f_clip(f_half(ar_x - bw_re, s2_sc_q));
  assign res_bi = f_clip(f_half(ai_x - bw_im, s2_sc_q));

  logic [CW-1:0] s3_a_q, s3_b_q;
  logic          s3_sat_q;

  always_ff @(posedge clk) begin
    s3_a_q   <= {res_ar[DATA_W-1:0], res_ai[DATA_W-1:0]};
    s3_b_q   <= {res_br[DATA_W-1:0], res_bi[DATA_W-1:0]};
    s3_sat_q <= res_ar[DATA_W] | res_ai[DATA_W] | res_br[DATA_W] | res_bi[DATA_W];
  end

  logic [2*CW-1:0] mem_q [BUFFER_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [CRW-1:0]  credits_used;
  logic            push, pop, sat_q, sat_d;

  assign push    = s3_v_q && (level_q != LW'(BUFFER_DEPTH));
  assign pop     = out_valid && out_ready;
  assign level_d = level_q + LW'(push) - LW'(pop);

  // A pop in this cycle does not free a credit until the next one.
  assign credits_used = CRW'(level_q) + CRW'(s1_v_q) + CRW'(s2_v_q) + CRW'(s3_v_q);
  assign in_ready     = !rst && (credits_used < CRW'(BUFFER_DEPTH));

  always_comb begin
    sat_d = sat_q;
    if (sat_clr)              sat_d = 1'b0;
    if (s3_v_q && s3_sat_q)   sat_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      sat_q   <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s3_a_q, s3_b_q};
  end

  assign out_valid      = (level_q != '0);
  assign {fft_a, fft_b} = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level          = level_q;
  assign sat_flag       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bfly_pe.sv
`default_nettype none
// ============================================================================
// tb_fft_bfly_pe : directed self-checking bench for fft_bfly_pe
// Revision       : 1.0
// ============================================================================
module tb_fft_bfly_pe;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] a = '0, b = '0, fft_a, fft_b;
  logic [15:0] tw_re = '0, tw_im = '0;
  logic        inverse = 1'b0, scale = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic        sat_flag, sat_clr = 1'b0;
  logic [3:0]  level;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  fft_bfly_pe #(.DATA_W(16), .TW_W(16), .BUFFER_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .tw_re(tw_re), .tw_im(tw_im), .inverse(inverse), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready), .fft_a(fft_a), .fft_b(fft_b),
    .sat_flag(sat_flag), .sat_clr(sat_clr), .level(level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] clamp16(input longint x);
    if (x > 32767)  return {1'b1, 16'h7FFF};
    if (x < -32768) return {1'b1, 16'h8000};
    return {1'b0, x[15:0]};
  endfunction

  // Returns {sat, A_re, A_im, B_re, B_im}.
  function automatic logic [64:0] bfly(input logic [31:0] av, bv, input logic [15:0] wr, wi,
                                       input logic inv, sc);
    longint ar, ai, br, bi, cr, ci, pr, pi;
    longint v [4];
    logic [16:0] c;
    logic [64:0] r;
    ar = longint'($signed(av[31:16])); ai = longint'($signed(av[15:0]));
    br = longint'($signed(bv[31:16])); bi = longint'($signed(bv[15:0]));
    cr = longint'($signed(wr));        ci = longint'($signed(wi));
    if (inv) ci = -ci;
    pr = (br * cr - bi * ci + 8192) >>> 14;
    pi = (br * ci + bi * cr + 8192) >>> 14;
    v[0] = ar + pr; v[1] = ai + pi; v[2] = ar - pr; v[3] = ai - pi;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (sc) v[k] = (v[k] + 1) >>> 1;
      c = clamp16(v[k]);
      r[64] = r[64] | c[16];
      r[63 - 16*k -: 16] = c[15:0];
    end
    return r;
  endfunction

  logic [63:0] exp_q [$];
  bit          mon_en = 1'b0, rnd_rdy = 1'b0;
  int          run = 0, maxrun = 0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (out_valid) run++; else run = 0;
    if (run > maxrun) maxrun = run;
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_beat", {fft_a, fft_b}, 64'h0BAD_0BAD_0BAD_0BAD ^ {fft_a, fft_b} ^ 64'h1);
      else begin
        e = exp_q.pop_front();
        check("stream_beat", {fft_a, fft_b}, e);
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] av, bv, input logic [15:0] wr, wi, input logic inv, sc);
    logic [64:0] m;
    int g;
    a = av; b = bv; tw_re = wr; tw_im = wi; inverse = inv; scale = sc; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    else begin
      m = bfly(av, bv, wr, wi, inv, sc);
      exp_q.push_back(m[63:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic one(input string tag, input logic [31:0] av, bv, input logic [15:0] wr, wi,
                     input logic inv, sc, clr, input logic [31:0] ea, eb, input logic esat);
    a = av; b = bv; tw_re = wr; tw_im = wi; inverse = inv; scale = sc;
    sat_clr = clr; in_valid = 1'b1;
    check({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check({tag, "_lat"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_a"}, fft_a, ea);
    check({tag, "_b"}, fft_b, eb);
    check({tag, "_sat"}, sat_flag, esat);
    sat_clr = 1'b0;
    @(posedge clk); #1;
    check({tag, "_hold"}, fft_a, ea);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_pop"}, level, 0);
  endtask

  logic [31:0] va [24], vb [24];
  logic [15:0] vwr [24], vwi [24];
  logic        vinv [24], vsc [24];

  initial begin
    logic [64:0] m;
    int acc;
    for (int i = 0; i < 24; i++) begin
      va[i]   = {16'($urandom_range(0, 16000)) - 16'd8000, 16'($urandom_range(0, 16000)) - 16'd8000};
      vb[i]   = {16'($urandom_range(0, 16000)) - 16'd8000, 16'($urandom_range(0, 16000)) - 16'd8000};
      vwr[i]  = 16'($urandom_range(0, 32768)) - 16'd16384;
      vwi[i]  = 16'($urandom_range(0, 32768)) - 16'd16384;
      vinv[i] = 1'($urandom_range(0, 1));
      vsc[i]  = 1'($urandom_range(0, 1));
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_fft_a", fft_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_ready", in_ready, 1);

    one("ident", 32'h0100_0000, 32'h0100_0000, 16'h4000, 16'h0000, 0, 0, 0,
        32'h0200_0000, 32'h0000_0000, 0);
    one("negj", 32'h0100_0000, 32'h0100_0000, 16'h0000, 16'hC000, 0, 0, 0,
        32'h0100_FF00, 32'h0100_0100, 0);
    one("negj_inv", 32'h0100_0000, 32'h0100_0000, 16'h0000, 16'hC000, 1, 0, 0,
        32'h0100_0100, 32'h0100_FF00, 0);
    one("sat_pos", 32'h7FFF_0000, 32'h7FFF_0000, 16'h4000, 16'h0000, 0, 0, 0,
        32'h7FFF_0000, 32'h0000_0000, 1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("sat_clr", sat_flag, 0);
    one("sat_scale", 32'h7FFF_0000, 32'h7FFF_0000, 16'h4000, 16'h0000, 0, 1, 0,
        32'h7FFF_0000, 32'h0000_0000, 0);
    one("sat_setwins", 32'h8000_0000, 32'h7FFF_0000, 16'h4000, 16'h0000, 0, 0, 1,
        32'hFFFF_0000, 32'h8000_0000, 1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;

    // Backpressure: consumer stalled, producer always offering.
    exp_q.delete();
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      a = va[acc]; b = vb[acc]; tw_re = vwr[acc]; tw_im = vwi[acc];
      inverse = vinv[acc]; scale = vsc[acc]; in_valid = 1'b1;
      if (in_ready) begin
        m = bfly(va[acc], vb[acc], vwr[acc], vwi[acc], vinv[acc], vsc[acc]);
        exp_q.push_back(m[63:0]);
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 8);
    check("bp_in_ready", in_ready, 0);
    check("bp_level", level, 8);
    mon_en = 1'b1;
    out_ready = 1'b1;
    for (int k = 8; k < 16; k++) send(va[k], vb[k], vwr[k], vwi[k], vinv[k], vsc[k]);
    in_valid = 1'b0;
    drain("bp_drain");
    repeat (2) @(posedge clk);
    #1;
    check("bp_level_end", level, 0);

    maxrun = 0;
    for (int k = 8; k < 24; k++) send(va[k], vb[k], vwr[k], vwi[k], vinv[k], vsc[k]);
    in_valid = 1'b0;
    drain("stream_drain");
    repeat (2) @(posedge clk);
    #1;
    check("stream_run", maxrun, 16);

    rnd_rdy = 1'b1;
    for (int k = 8; k < 24; k++) send(va[k], vb[k], vwr[k], vwi[k], vinv[k], vsc[k]);
    in_valid = 1'b0;
    drain("rnd_drain");
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with 3 beats in the FIFO and 2 still in the pipeline.
    mon_en = 1'b0;
    send(32'h7FFF_0000, 32'h7FFF_0000, 16'h4000, 16'h0000, 0, 0);
    for (int k = 0; k < 4; k++) send(va[k], vb[k], vwr[k], vwi[k], vinv[k], vsc[k]);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_pre_level", level, 3);
    check("mid_pre_sat", sat_flag, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_level", level, 0);
    check("mid_sat", sat_flag, 0);
    check("mid_fft_a", fft_a, 0);
    check("mid_in_ready", in_ready, 0);
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_no_stale", level, 0);
    send(va[0], vb[0], vwr[0], vwi[0], vinv[0], vsc[0]);
    in_valid = 1'b0;
    drain("mid_fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
